// File: rtl/mul_step_seq_pkg.sv
// -----------------------------------------------------------------------------
// mul_step_pkg
// Shared definitions for the iterative multiply sequencer and the AD adder
// chain it drives.
//   AD_S_PASS / AD_S_ADD / AD_S_SUB : AD function-select codes (mode M=0)
//   state_e                         : sequencer states IDLE, STEP, DONE
// -----------------------------------------------------------------------------
package mul_step_pkg;

    localparam logic [3:0] AD_S_PASS = 4'b0000;   // F = A        (CIN=0)
    localparam logic [3:0] AD_S_ADD  = 4'b0110;   // F = A + B    (CIN=0)
    localparam logic [3:0] AD_S_SUB  = 4'b1001;   // F = A + ~B + CIN, CIN=1 gives A - B

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mul_step_seq_if.sv
// -----------------------------------------------------------------------------
// mul_step_seq_if
// Request/response bundle between a multiply requester and mul_step_seq.
//   START        : begin a multiply (requester -> sequencer)
//   MPLIER/MCAND : operands, captured on an accepted START
//   UNS          : unsigned select, present only with MULSTEP_UNSIGNED_EN
//   BUSY/DONE    : status, DONE is a one-cycle completion pulse
//   PROD         : registered 2*WIDTH product {ACC, MQ}
// Modports: master = requester side, slave = sequencer side.
// Optional feature macro: MULSTEP_UNSIGNED_EN.
// -----------------------------------------------------------------------------
interface mul_step_seq_if #(
    parameter int WIDTH = 36
);

    logic                 START;
    logic [WIDTH-1:0]     MPLIER;
    logic [WIDTH-1:0]     MCAND;
`ifdef MULSTEP_UNSIGNED_EN
    logic                 UNS;
`endif
    logic                 BUSY;
    logic                 DONE;
    logic [2*WIDTH-1:0]   PROD;

`ifdef MULSTEP_UNSIGNED_EN
    modport master (output START, MPLIER, MCAND, UNS, input BUSY, DONE, PROD);
    modport slave  (input START, MPLIER, MCAND, UNS, output BUSY, DONE, PROD);
`else
    modport master (output START, MPLIER, MCAND, input BUSY, DONE, PROD);
    modport slave  (input START, MPLIER, MCAND, output BUSY, DONE, PROD);
`endif

endinterface

// File: rtl/ad_chain.sv
// -----------------------------------------------------------------------------
// ad_chain
// AD adder chain: WIDTH/4 ripple-connected 4-bit ALU slices. Slice 0 takes
// CIN, each slice's carry feeds the next, the top slice's carry is COUT.
//   A, B : operands          S : function select     M : mode (0 = arithmetic)
//   CIN  : carry into slice 0
//   F    : result            COUT : carry out of the top slice
// Arithmetic functions: PASS (F=A+CIN), ADD (F=A+B+CIN), SUB (F=A+~B+CIN).
// Logic mode (M=1) gives F = A ^ B with no carry.
// -----------------------------------------------------------------------------
module ad_chain
    import mul_step_pkg::*;
#(
    parameter int WIDTH = 36
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       S,
    input  logic             M,
    input  logic             CIN,
    output logic [WIDTH-1:0] F,
    output logic             COUT
);

    localparam int NSLICE = WIDTH / 4;

    logic       carry;
    logic [3:0] a_nib;
    logic [3:0] b_nib;
    logic [3:0] b_sel;
    logic [4:0] nib_sum;

    // Walk the slices from least to most significant, rippling the carry.
    always_comb begin
        carry   = CIN;
        F       = '0;
        a_nib   = '0;
        b_nib   = '0;
        b_sel   = '0;
        nib_sum = '0;
        for (int i = 0; i < NSLICE; i++) begin
            a_nib = A[4*i +: 4];
            b_nib = B[4*i +: 4];
            case (S)
                AD_S_ADD: b_sel = b_nib;
                AD_S_SUB: b_sel = ~b_nib;
                default:  b_sel = 4'b0000;
            endcase
            nib_sum = {1'b0, a_nib} + {1'b0, b_sel} + {4'b0000, carry};
            if (M) begin
                F[4*i +: 4] = a_nib ^ b_nib;
                carry       = 1'b0;
            end else begin
                F[4*i +: 4] = nib_sum[3:0];
                carry       = nib_sum[4];
            end
        end
        COUT = carry;
    end

endmodule

// File: rtl/mul_step_seq.sv
// -----------------------------------------------------------------------------
// mul_step_seq
// Iterative WIDTH x WIDTH two's-complement multiplier sequencer. Each STEP
// cycle it asks the external AD chain for ACC (+/-) MCR or a pass-through,
// then shifts {X, AD_F, MQ} right by one into {ACC, MQ}. After WIDTH steps
// {ACC, MQ} holds the 2*WIDTH product.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   bus (slave)         : START/MPLIER/MCAND[/UNS] in, BUSY/DONE/PROD out
//   AD_S, AD_M, AD_A,
//   AD_B, AD_CIN        : drive to the AD chain (from registered state only)
//   AD_F, AD_COUT       : combinational return from the AD chain
// Optional feature macro: MULSTEP_UNSIGNED_EN adds bus.UNS; when captured
// high the product is unsigned.
// -----------------------------------------------------------------------------
module mul_step_seq
    import mul_step_pkg::*;
#(
    parameter int WIDTH = 36,
    parameter int CNTW  = 6
) (
    input  logic              clk,
    input  logic              reset,
    mul_step_seq_if.slave     bus,
    output logic [3:0]        AD_S,
    output logic              AD_M,
    output logic [WIDTH-1:0]  AD_A,
    output logic [WIDTH-1:0]  AD_B,
    output logic              AD_CIN,
    input  logic [WIDTH-1:0]  AD_F,
    input  logic              AD_COUT
);

    generate
        if ((WIDTH % 4) != 0 || WIDTH < 8 || (1 << CNTW) <= WIDTH) begin : g_bad_param
            $error("mul_step_seq: WIDTH must be a multiple of 4, >= 8, and < 2**CNTW");
        end
    endgenerate

    state_e            state_q;
    logic              busy_q;
    logic              done_q;

    logic [WIDTH-1:0]  acc_q,   acc_d;
    logic [WIDTH-1:0]  mq_q,    mq_d;
    logic [WIDTH-1:0]  mcr_q,   mcr_d;
    logic [CNTW-1:0]   count_q, count_d;
`ifdef MULSTEP_UNSIGNED_EN
    logic              uns_q,   uns_d;
`endif

    logic              last_step;
    logic              uns_mode;
    logic [3:0]        op_s;
    logic              op_cin;
    logic              ext_bit;

    assign last_step = (count_q == CNTW'(WIDTH - 1));

`ifdef MULSTEP_UNSIGNED_EN
    assign uns_mode = uns_q;
`else
    assign uns_mode = 1'b0;
`endif

    // Step decode. The signed recoding subtracts on the last multiplier bit
    // because that bit carries negative weight. X is the true sign (or the
    // unsigned carry) of the WIDTH+1-bit partial sum, so the right shift keeps
    // the full precision of ACC.
    always_comb begin
        op_s    = AD_S_PASS;
        op_cin  = 1'b0;
        ext_bit = uns_mode ? 1'b0 : acc_q[WIDTH-1];
        if (state_q == STEP && mq_q[0]) begin
            if (last_step && !uns_mode) begin
                op_s    = AD_S_SUB;
                op_cin  = 1'b1;
                ext_bit = acc_q[WIDTH-1] ^ ~mcr_q[WIDTH-1] ^ AD_COUT;
            end else begin
                op_s    = AD_S_ADD;
                ext_bit = uns_mode ? AD_COUT
                                   : (acc_q[WIDTH-1] ^ mcr_q[WIDTH-1] ^ AD_COUT);
            end
        end
    end

    assign AD_S   = op_s;
    assign AD_M   = 1'b0;
    assign AD_A   = acc_q;
    assign AD_B   = mcr_q;
    assign AD_CIN = op_cin;

    // Datapath next-state: load operands on an accepted START, shift once
    // per STEP cycle, hold otherwise (so PROD survives DONE and IDLE).
    always_comb begin
        acc_d   = acc_q;
        mq_d    = mq_q;
        mcr_d   = mcr_q;
        count_d = count_q;
`ifdef MULSTEP_UNSIGNED_EN
        uns_d   = uns_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.START) begin
                    acc_d   = '0;
                    mq_d    = bus.MPLIER;
                    mcr_d   = bus.MCAND;
                    count_d = '0;
`ifdef MULSTEP_UNSIGNED_EN
                    uns_d   = bus.UNS;
`endif
                end
            end
            STEP: begin
                {acc_d, mq_d} = {ext_bit, AD_F, mq_q[WIDTH-1:1]};
                count_d       = count_q + 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q   <= '0;
            mq_q    <= '0;
            mcr_q   <= '0;
            count_q <= '0;
`ifdef MULSTEP_UNSIGNED_EN
            uns_q   <= 1'b0;
`endif
        end else begin
            acc_q   <= acc_d;
            mq_q    <= mq_d;
            mcr_q   <= mcr_d;
            count_q <= count_d;
`ifdef MULSTEP_UNSIGNED_EN
            uns_q   <= uns_d;
`endif
        end
    end

    // Sequencer with registered BUSY/DONE. START outside IDLE is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.START) begin
                        state_q <= STEP;
                        busy_q  <= 1'b1;
                    end
                end
                STEP: begin
                    if (last_step) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.BUSY = busy_q;
    assign bus.DONE = done_q;
    assign bus.PROD = {acc_q, mq_q};

endmodule
